// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: launches Mult/Div, stalls EX until the result arrives,
// commits HI/LO, services MTHI/MTLO/MFHI/MFLO and flags an unanswered unit.
module hilo_muldiv_ctrl #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        mul_validOut,
  input  logic [31:0] Mult_Hi,
  input  logic [31:0] Mult_Lo,
  input  logic        div_validOut,
  input  logic [31:0] Div_Hi,
  input  logic [31:0] Div_Lo,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        mul_validIn,
  output logic        div_validIn,
  output logic        mul_sign,
  output logic        div_sign,
  output logic        stall,
  output logic        busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] hilo_rdata,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MUL, WAIT_DIV} state_t;

  state_t        state_q, state_d;
  logic          sel_div_q, sel_div_d;
  logic          sign_q, sign_d;
  logic [31:0]   opa_q, opa_d, opb_q, opb_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic is_mfhi, is_mthi, is_mflo, is_mtlo, is_mul, is_div;

  always_comb begin
    is_mfhi = op_valid && (funct == F_MFHI);
    is_mthi = op_valid && (funct == F_MTHI);
    is_mflo = op_valid && (funct == F_MFLO);
    is_mtlo = op_valid && (funct == F_MTLO);
    is_mul  = op_valid && ((funct == F_MULT) || (funct == F_MULTU));
    is_div  = op_valid && ((funct == F_DIV) || (funct == F_DIVU));
  end

  // Next-state, datapath updates and launch/stall decode.
  always_comb begin
    state_d     = state_q;
    sel_div_d   = sel_div_q;
    sign_d      = sign_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    terr_d      = terr_q;
    stall       = 1'b0;
    mul_validIn = 1'b0;
    div_validIn = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_mthi) hi_d = SrcA;
        if (is_mtlo) lo_d = SrcA;
        // Divide by zero is dropped here so the unit is never launched.
        if (is_mul || (is_div && (SrcB != 32'd0))) begin
          opa_d     = SrcA;
          opb_d     = SrcB;
          sign_d    = ~funct[0];
          sel_div_d = is_div;
          state_d   = ISSUE;
          stall     = 1'b1;
        end
      end
      ISSUE: begin
        stall       = 1'b1;
        mul_validIn = ~sel_div_q;
        div_validIn = sel_div_q;
        cnt_d       = '0;
        state_d     = sel_div_q ? WAIT_DIV : WAIT_MUL;
      end
      WAIT_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (mul_validOut) begin
          hi_d    = Mult_Hi;
          lo_d    = Mult_Lo;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (div_validOut) begin
          hi_d    = Div_Hi;
          lo_d    = Div_Lo;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_div_q <= 1'b0;
      sign_q    <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_div_q <= sel_div_d;
      sign_q    <= sign_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
    end
  end

  assign opA         = opa_q;
  assign opB         = opb_q;
  assign mul_sign    = sign_q & ~sel_div_q;
  assign div_sign    = sign_q & sel_div_q;
  assign busy        = (state_q != IDLE);
  assign Hi          = hi_q;
  assign Lo          = lo_q;
  assign timeout_err = terr_q;
  assign hilo_rdata  = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);

endmodule
